// File: rtl/div_ratio_detector_pkg.sv
// Shared types and defaults for the divided-clock ratio detector.
package div_ratio_pkg;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_LOCK_N = 3;
   localparam int MATCH_W    = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

endpackage

// File: rtl/div_ratio_detector_if.sv
// Divided clock in, measured ratio and status flags out; no flow control.
interface div_ratio_detector_if #(
   parameter int CNT_W = div_ratio_pkg::DEF_CNT_W
);

   logic             div_in;
   logic [CNT_W-1:0] ratio;
   logic             period_stb;
   logic             ratio_valid;
   logic             duty_ok;
   logic             even;
   logic             err;

   modport master (
      output div_in,
      input  ratio, period_stb, ratio_valid, duty_ok, even, err
   );

   modport slave (
      input  div_in,
      output ratio, period_stb, ratio_valid, duty_ok, even, err
   );

endinterface

// File: rtl/div_ratio_detector_edge_detect.sv
// Rising-edge detector for a clk-synchronous divided clock.
// o_rise is combinational from i_div_in and the registered previous sample.
module div_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_div_in,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (reset) r_prev <= 1'b0;
      else       r_prev <= i_div_in;
   end

   assign o_rise = i_div_in & ~r_prev;

endmodule

// File: rtl/div_ratio_detector.sv
// Measures period/high time of div_in in clk cycles and locks after LOCK_N equal periods.
// Latency 1 clk from the rise cycle to all outputs; no backpressure.
module div_ratio_detector
   import div_ratio_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int LOCK_N = DEF_LOCK_N
) (
   input  logic                clk,
   input  logic                reset,
   div_ratio_detector_if.slave det_if
);

   localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
   localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
   localparam logic [MATCH_W-1:0] LOCK_M    = MATCH_W'(LOCK_N);

   logic               w_rise;
   logic               w_ovf;
   logic               w_same;
   logic               w_duty_hit;
   logic [MATCH_W-1:0] w_match_new;

   logic [CNT_W-1:0]   r_per_cnt;
   logic [CNT_W-1:0]   r_high_cnt;

   state_t             r_state;
   state_t             w_nxt_state;
   logic [CNT_W-1:0]   r_ratio,  w_nxt_ratio;
   logic [MATCH_W-1:0] r_match,  w_nxt_match;
   logic               r_stb,    w_nxt_stb;
   logic               r_valid,  w_nxt_valid;
   logic               r_duty,   w_nxt_duty;
   logic               r_even,   w_nxt_even;
   logic               r_err,    w_nxt_err;

   div_edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .i_div_in (det_if.div_in),
      .o_rise   (w_rise)
   );

   // Counters saturate so a stuck input reads as all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_per_cnt  <= '0;
         r_high_cnt <= '0;
      end else if (w_rise) begin
         r_per_cnt  <= CNT_ONE;
         r_high_cnt <= CNT_ONE;
      end else begin
         if (r_per_cnt != CNT_MAX)
            r_per_cnt <= r_per_cnt + CNT_ONE;
         if (det_if.div_in && (r_high_cnt != CNT_MAX))
            r_high_cnt <= r_high_cnt + CNT_ONE;
      end
   end

   assign w_ovf       = (r_per_cnt == CNT_MAX) && !w_rise;
   assign w_same      = (r_per_cnt == r_ratio);
   assign w_duty_hit  = ({r_high_cnt, 1'b0} == {1'b0, r_per_cnt});
   assign w_match_new = !w_same             ? MATCH_ONE :
                        (r_match == MATCH_MAX) ? r_match : r_match + MATCH_ONE;

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ratio = r_ratio;
      w_nxt_match = r_match;
      w_nxt_valid = r_valid;
      w_nxt_duty  = r_duty;
      w_nxt_even  = r_even;
      w_nxt_stb   = 1'b0;
      w_nxt_err   = 1'b0;

      case (r_state)
         IDLE: begin
            // The first rise only opens a period; there is nothing to measure yet.
            if (w_rise) begin
               w_nxt_state = MEASURE;
               w_nxt_match = '0;
            end
         end

         MEASURE: begin
            if (w_rise) begin
               w_nxt_stb   = 1'b1;
               w_nxt_ratio = r_per_cnt;
               w_nxt_even  = ~r_per_cnt[0];
               w_nxt_duty  = w_duty_hit;
               w_nxt_match = w_match_new;
               if (w_match_new >= LOCK_M) begin
                  w_nxt_state = LOCKED;
                  w_nxt_valid = 1'b1;
               end
            end else if (w_ovf) begin
               w_nxt_err   = 1'b1;
               w_nxt_valid = 1'b0;
               w_nxt_match = '0;
               w_nxt_state = IDLE;
            end
         end

         LOCKED: begin
            if (w_rise) begin
               w_nxt_stb   = 1'b1;
               w_nxt_ratio = r_per_cnt;
               w_nxt_even  = ~r_per_cnt[0];
               w_nxt_duty  = w_duty_hit;
               if (!w_same) begin
                  w_nxt_err   = 1'b1;
                  w_nxt_match = MATCH_ONE;
                  w_nxt_valid = 1'b0;
                  w_nxt_state = MEASURE;
               end
            end else if (w_ovf) begin
               w_nxt_err   = 1'b1;
               w_nxt_valid = 1'b0;
               w_nxt_match = '0;
               w_nxt_state = IDLE;
            end
         end

         default: begin
            w_nxt_state = IDLE;
            w_nxt_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ratio <= '0;
         r_match <= '0;
         r_stb   <= 1'b0;
         r_valid <= 1'b0;
         r_duty  <= 1'b0;
         r_even  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_ratio <= w_nxt_ratio;
         r_match <= w_nxt_match;
         r_stb   <= w_nxt_stb;
         r_valid <= w_nxt_valid;
         r_duty  <= w_nxt_duty;
         r_even  <= w_nxt_even;
         r_err   <= w_nxt_err;
      end
   end

   assign det_if.ratio       = r_ratio;
   assign det_if.period_stb  = r_stb;
   assign det_if.ratio_valid = r_valid;
   assign det_if.duty_ok     = r_duty;
   assign det_if.even        = r_even;
   assign det_if.err         = r_err;

endmodule

// File: doc/div_ratio_detector.md
DIV_RATIO_DETECTOR -- requirements
Module: div_ratio_detector

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, setting the width of the period and high-time counters.
REQ-002 The module SHALL have parameter LOCK_N, default 3, giving the number of consecutive equal periods required for lock (legal range 1..15).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port div_in, input, 1 bit: divided clock under test, generated from clk and synchronous to it (no synchronizer).
REQ-006 The module SHALL have port ratio, output, CNT_W bits: last measured period of div_in, in clk cycles.
REQ-007 The module SHALL have port period_stb, output, 1 bit: one-cycle pulse each time a new period is measured.
REQ-008 The module SHALL have port ratio_valid, output, 1 bit: high while locked.
REQ-009 The module SHALL have port duty_ok, output, 1 bit: last period had high time exactly equal to half the period.
REQ-010 The module SHALL have port even, output, 1 bit: last measured period is even.
REQ-011 The module SHALL have port err, output, 1 bit: one-cycle pulse on loss of lock or counter overflow.

Function
REQ-012 The block SHALL register div_in as prev and define rise = div_in & ~prev.
REQ-013 The period counter SHALL load 1 on a rise cycle and increment by 1 otherwise.
REQ-014 The high counter SHALL load 1 on a rise cycle and add div_in otherwise.
REQ-015 On a rise in MEASURE or LOCKED, the measured period SHALL be the pre-load period-counter value (div2 gives 2, div4 gives 4, div6 gives 6).
REQ-016 The block SHALL have FSM states IDLE, MEASURE and LOCKED.
REQ-017 IDLE SHALL go to MEASURE on the first rise, with no period_stb and no measurement.
REQ-018 In MEASURE, each rise SHALL pulse period_stb and update ratio, even = ~period[0], and duty_ok = (2*high == period).
REQ-019 In MEASURE, each rise SHALL set the match counter to (period == ratio) ? match+1 : 1.
REQ-020 MEASURE SHALL go to LOCKED, with ratio_valid high, on the rise at which the match counter reaches LOCK_N.
REQ-021 In LOCKED, a rise with period equal to ratio SHALL pulse period_stb only; state and ratio_valid are unchanged.
REQ-022 In LOCKED, a rise with period not equal to ratio SHALL pulse err and period_stb, update ratio, set the match counter to 1, clear ratio_valid and return to MEASURE.
REQ-023 In MEASURE or LOCKED, a period counter at all-ones without a rise SHALL pulse err, clear ratio_valid and go to IDLE; counters SHALL saturate and never wrap.
REQ-024 All outputs SHALL be registered, appearing 1 clk after the rise cycle (latency 1).
REQ-025 With LOCK_N = 1, the first measured period SHALL lock.
REQ-026 If div_in is constant 0 or 1, the block SHALL make no rise, no period_stb and no lock, and SHALL signal overflow err per REQ-023 once in MEASURE or LOCKED.

Reset
REQ-027 When reset is high at a clk edge, the block SHALL go to IDLE and clear prev, the counters, ratio, period_stb, ratio_valid, duty_ok, even and err to 0.
REQ-028 Reset SHALL take priority over every event, including a simultaneous rise.
REQ-029 Reset mid-period SHALL discard the partial measurement, and lock SHALL restart from the first rise after release.

Structure
REQ-030 Package div_ratio_pkg SHALL hold the state enum (IDLE, MEASURE, LOCKED) and the default CNT_W and LOCK_N constants.
REQ-031 Edge detection (prev register plus rise output) SHALL be the sub-module div_edge_detect; all other logic sits in the top.

Verification
REQ-032 The bench SHALL cover: div2 source, reset released at t=20 -> period_stb every 2 clk, ratio=2, even=1, duty_ok=1, ratio_valid high 1 clk after the 4th rise.
REQ-033 The bench SHALL cover: div4, then div6 source -> ratio=4 locked, then ratio=6 locked, with even=1 and duty_ok=1 throughout.
REQ-034 The bench SHALL cover: locked on div4, then one period stretched to 5 -> err pulse, ratio=5, even=0, ratio_valid=0, relock at 4 after 3 further equal periods.
REQ-035 The bench SHALL cover: div_in held 1 for 300 clk while locked -> err pulse when the counter reaches 255, state IDLE, ratio_valid=0.
REQ-036 The bench SHALL cover: reset pulsed for 2 clk mid-period while locked -> all outputs 0 next clk, lock restarts from the first rise after release.
REQ-037 The bench SHALL cover: divide-by-3 source (high 1, low 2) -> ratio=3, even=0, duty_ok=0, ratio_valid=1 after lock.
